disp_scan_ctrl: RTL

- Time-multiplexed 7-segment scan controller for the BCD display path.
- Consumes the one-cycle tick from the slow-clock tick generator.
- Sequences digit anodes with a dead-time gap between digits to suppress ghosting.
- Double-buffers the BCD word via a valid/ready load handshake, so new values commit only at frame boundaries. It also applies leading-zero blanking.

---
 rtl/disp_scan_ctrl_pkg.sv | 23 ++
 rtl/bcd_seg_decode.sv | 28 ++
 rtl/disp_scan_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/disp_scan_ctrl_pkg.sv
// Shared types and segment codes for the BCD display path.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package disp_scan_ctrl_pkg;

    typedef enum logic {
        ST_SHOW = 1'b0,
        ST_DEAD = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_D0    = 7'h40;
    localparam logic [6:0] SEG_D1    = 7'h79;
    localparam logic [6:0] SEG_D2    = 7'h24;
    localparam logic [6:0] SEG_D3    = 7'h30;
    localparam logic [6:0] SEG_D4    = 7'h19;
    localparam logic [6:0] SEG_D5    = 7'h12;
    localparam logic [6:0] SEG_D6    = 7'h02;
    localparam logic [6:0] SEG_D7    = 7'h78;
    localparam logic [6:0] SEG_D8    = 7'h00;
    localparam logic [6:0] SEG_D9    = 7'h10;

endpackage

// File: rtl/bcd_seg_decode.sv
// Combinational BCD nibble to active-low 7-segment decoder.
// Non-BCD nibbles render as a dash.
module bcd_seg_decode
    import disp_scan_ctrl_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Nibble lookup; A-F fall through to the dash glyph
    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_D0;
            4'd1:    seg = SEG_D1;
            4'd2:    seg = SEG_D2;
            4'd3:    seg = SEG_D3;
            4'd4:    seg = SEG_D4;
            4'd5:    seg = SEG_D5;
            4'd6:    seg = SEG_D6;
            4'd7:    seg = SEG_D7;
            4'd8:    seg = SEG_D8;
            4'd9:    seg = SEG_D9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Multiplexed 7-segment scan controller with dead-time between digits,
// frame-aligned double-buffered BCD load and leading-zero blanking.
module disp_scan_ctrl
    import disp_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DEAD_TICKS = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick_in,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic                    blank_lz,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic [6:0]              seg_out,
    output logic                    frame_done
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;
    localparam int BW = 4 * NUM_DIGITS;
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [DW-1:0] CNT_LAST = DW'(DEAD_TICKS - 1);

    scan_state_t state_q, state_d;
    logic [IW-1:0] idx_q, idx_d, idx_inc;
    logic [DW-1:0] cnt_q, cnt_d;
    logic boot_q, boot_d;
    logic boundary;

    logic [BW-1:0] active_q, active_d;
    logic [BW-1:0] pend_q, pend_d;
    logic pend_full_q, pend_full_d;

    logic [NUM_DIGITS-1:0] lz_mask;
    logic zero_run;
    logic [3:0] dig;
    logic [6:0] dec_seg;

    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0] seg_q, seg_d;
    logic done_q;

    // State, buffers and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_DEAD;
            idx_q       <= IDX_LAST;
            cnt_q       <= '0;
            boot_q      <= 1'b1;
            active_q    <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            an_q        <= '1;
            seg_q       <= SEG_BLANK;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            boot_q      <= boot_d;
            active_q    <= active_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            done_q      <= boundary;
        end
    end

    // Scan sequencing: slot and dead-time stepping on each tick
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        boot_d   = boot_q;
        boundary = 1'b0;
        idx_inc  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        if (tick_in) begin
            unique case (state_q)
                ST_SHOW: begin
                    if (DEAD_TICKS > 0) begin
                        state_d = ST_DEAD;
                        cnt_d   = '0;
                    end else begin
                        idx_d = idx_inc;
                    end
                end
                ST_DEAD: begin
                    if (boot_q || cnt_q == CNT_LAST) begin
                        state_d = ST_SHOW;
                        idx_d   = idx_inc;
                        boot_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
            boundary = (state_d == ST_SHOW) && (idx_d == '0);
        end
    end

    // Pending buffer fill and commit into the active buffer at frame start
    always_comb begin
        active_d    = active_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        if (boundary && pend_full_q) begin
            active_d    = pend_q;
            pend_full_d = 1'b0;
        end
        if (load_valid && !pend_full_q) begin
            pend_d      = bcd_in;
            pend_full_d = 1'b1;
        end
    end

    // Digit i is a leading zero when it and everything above it is zero
    always_comb begin
        lz_mask  = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run   = zero_run && (active_d[4*i +: 4] == 4'd0);
            lz_mask[i] = zero_run;
        end
    end

    assign dig = active_d[{idx_d, 2'b00} +: 4];

    bcd_seg_decode u_dec (
        .bcd (dig),
        .seg (dec_seg)
    );

    // Output image for the slot being entered on this tick
    always_comb begin
        an_d  = an_q;
        seg_d = seg_q;
        if (tick_in) begin
            an_d  = '1;
            seg_d = SEG_BLANK;
            if (state_d == ST_SHOW && !(blank_lz && lz_mask[idx_d])) begin
                an_d[idx_d] = 1'b0;
                seg_d       = dec_seg;
            end
        end
    end

    assign load_ready = ~pend_full_q;
    assign an_out     = an_q;
    assign seg_out    = seg_q;
    assign frame_done = done_q;

endmodule
